// File: rtl/morse_pkg.sv
// morse_pkg: ASCII ranges, Morse symbol type and output FSM states for morse_char_queue.
// With MORSE_LOWERCASE_EN defined, fold_upper maps 'a'..'z' onto 'A'..'Z'.
package morse_pkg;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [3:0] MORSE_SPACE_LEN = 4'd0;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] len;
    } morse_sym_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_t;

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
`ifdef MORSE_LOWERCASE_EN
        return (c >= ASCII_LA && c <= ASCII_LZ) ? c - 8'h20 : c;
`else
        return c;
`endif
    endfunction
endpackage

// File: rtl/morse_char_queue_lut.sv
// morse_lut: combinational ASCII to Morse translation with a validity flag.
// Lowercase input is folded before lookup, so it is only valid with MORSE_LOWERCASE_EN.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0] char_i,
    output morse_sym_t sym_o,
    output logic       valid_o
);
    logic [7:0] c;

    assign c = fold_upper(char_i);

    // code is left-aligned, 1 = dash; len 0 marks a word space
    always_comb begin
        sym_o   = {8'h00, MORSE_SPACE_LEN};
        valid_o = 1'b1;
        case (c)
            ASCII_SPACE: sym_o = {8'h00, MORSE_SPACE_LEN};
            "A": sym_o = {8'h40, 4'd2};
            "B": sym_o = {8'h80, 4'd4};
            "C": sym_o = {8'hA0, 4'd4};
            "D": sym_o = {8'h80, 4'd3};
            "E": sym_o = {8'h00, 4'd1};
            "F": sym_o = {8'h20, 4'd4};
            "G": sym_o = {8'hC0, 4'd3};
            "H": sym_o = {8'h00, 4'd4};
            "I": sym_o = {8'h00, 4'd2};
            "J": sym_o = {8'h70, 4'd4};
            "K": sym_o = {8'hA0, 4'd3};
            "L": sym_o = {8'h40, 4'd4};
            "M": sym_o = {8'hC0, 4'd2};
            "N": sym_o = {8'h80, 4'd2};
            "O": sym_o = {8'hE0, 4'd3};
            "P": sym_o = {8'h60, 4'd4};
            "Q": sym_o = {8'hD0, 4'd4};
            "R": sym_o = {8'h40, 4'd3};
            "S": sym_o = {8'h00, 4'd3};
            "T": sym_o = {8'h80, 4'd1};
            "U": sym_o = {8'h20, 4'd3};
            "V": sym_o = {8'h10, 4'd4};
            "W": sym_o = {8'h60, 4'd3};
            "X": sym_o = {8'h90, 4'd4};
            "Y": sym_o = {8'hB0, 4'd4};
            "Z": sym_o = {8'hC0, 4'd4};
            "0": sym_o = {8'hF8, 4'd5};
            "1": sym_o = {8'h78, 4'd5};
            "2": sym_o = {8'h38, 4'd5};
            "3": sym_o = {8'h18, 4'd5};
            "4": sym_o = {8'h08, 4'd5};
            "5": sym_o = {8'h00, 4'd5};
            "6": sym_o = {8'h80, 4'd5};
            "7": sym_o = {8'hC0, 4'd5};
            "8": sym_o = {8'hE0, 4'd5};
            "9": sym_o = {8'hF0, 4'd5};
            default: valid_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/morse_char_queue.sv
// morse_char_queue: filtered ASCII FIFO feeding the Morse encoder via char_vald/char_next.
// MORSE_LOWERCASE_EN (optional) accepts 'a'..'z' and stores them as uppercase.
module morse_char_queue
    import morse_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_char,
    output logic          full,
    output logic [AW:0]   level,
    output logic [7:0]    charcode,
    output logic [3:0]    charlen,
    output logic          char_vald,
    input  logic          char_next,
    output logic          err_invalid,
    output logic          err_overflow,
    input  logic          clr_err
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    out_state_t    state_q, state_d;
    morse_sym_t    sym_q, sym_d;
    logic          err_inv_q, err_inv_d, err_ovf_q, err_ovf_d;
    logic [7:0]    wr_byte, rd_byte;
    logic          wr_valid, rd_valid_unused, push, pop;
    morse_sym_t    wr_sym_unused, rd_sym;

    assign wr_byte = fold_upper(wr_char);
    assign rd_byte = mem_q[rd_ptr_q];

    morse_lut u_wr_lut (.char_i(wr_char), .sym_o(wr_sym_unused), .valid_o(wr_valid));
    morse_lut u_rd_lut (.char_i(rd_byte), .sym_o(rd_sym), .valid_o(rd_valid_unused));

    assign full      = level_q == DEPTH[AW:0];
    assign level     = level_q;
    assign char_vald = state_q == OUT_HOLD;
    assign charcode  = sym_q.code;
    assign charlen   = sym_q.len;
    assign err_invalid  = err_inv_q;
    assign err_overflow = err_ovf_q;

    // full is the pre-edge value, so a same-cycle pop never makes room for a write
    always_comb begin
        push      = wr_en && wr_valid && !full;
        pop       = (level_q != '0) && (state_q == OUT_EMPTY || char_next);
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d   = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        state_d   = pop ? OUT_HOLD : (char_next ? OUT_EMPTY : state_q);
        sym_d     = pop ? rd_sym : sym_q;
        err_inv_d = !clr_err && (err_inv_q || (wr_en && !wr_valid));
        err_ovf_d = !clr_err && (err_ovf_q || (wr_en && full));
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= OUT_EMPTY;
            sym_q     <= '0;
            err_inv_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            sym_q     <= sym_d;
            err_inv_q <= err_inv_d;
            err_ovf_q <= err_ovf_d;
        end
    end
endmodule
